// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO controller driving an external 1-cycle-latency RAM, with count and status flags.
// Optional status ports (CNT, OVF, UDF, CLR_ERR) are enabled by defining FIFO_SYNC_CTRL_STATUS_EN.
module fifo_sync_ctrl #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 7,
  parameter int AFULL_TH  = 120,
  parameter int AEMPTY_TH = 8
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              WE,
  input  logic [WIDTH-1:0]  DATA,
  input  logic              RE,
  output logic [WIDTH-1:0]  Q,
  output logic              DVLD,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic              RAM_WEN,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [WIDTH-1:0]  RAM_WDATA,
  output logic              RAM_REN,
  output logic [ADDR_W-1:0] RAM_RADDR,
  input  logic [WIDTH-1:0]  RAM_RDATA
`ifdef FIFO_SYNC_CTRL_STATUS_EN
  ,
  output logic [ADDR_W:0]   CNT,
  output logic              OVF,
  output logic              UDF,
  input  logic              CLR_ERR
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0] ONE_C     = (ADDR_W+1)'(1);

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            dvld_q, dvld_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            afull_q, afull_d;
  logic            aempty_q, aempty_d;
  logic            wr_ok, rd_ok;

  // Strobes are gated by RESET_N so the RAM sees no access while reset is held.
  always_comb begin
    wr_ok   = WE & ~full_q & RESET_N;
    rd_ok   = RE & ~empty_q & RESET_N;
    wptr_d  = wr_ok ? wptr_q + ONE_C : wptr_q;
    rptr_d  = rd_ok ? rptr_q + ONE_C : rptr_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    dvld_d   = rd_ok;
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dvld_q   <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dvld_q   <= dvld_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign Q         = RAM_RDATA;
  assign DVLD      = dvld_q;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign RAM_WEN   = wr_ok;
  assign RAM_WADDR = wptr_q[ADDR_W-1:0];
  assign RAM_WDATA = DATA;
  assign RAM_REN   = rd_ok;
  assign RAM_RADDR = rptr_q[ADDR_W-1:0];

`ifdef FIFO_SYNC_CTRL_STATUS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A dropped request sets its sticky flag even when CLR_ERR is asserted in the same cycle.
  always_comb begin
    ovf_d = CLR_ERR ? 1'b0 : ovf_q;
    udf_d = CLR_ERR ? 1'b0 : udf_q;
    if (WE && full_q)  ovf_d = 1'b1;
    if (RE && empty_q) udf_d = 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign CNT = count_q;
  assign OVF = ovf_q;
  assign UDF = udf_q;
`endif

endmodule

// File: doc/fifo_sync_ctrl.md
FIFO_SYNC_CTRL -- requirements
Module: fifo_sync_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 7: RAM address width, so depth = 2^ADDR_W = 128.
REQ-003 The block SHALL have parameter AFULL_TH, default 120: AFULL asserts when count >= AFULL_TH.
REQ-004 The block SHALL have parameter AEMPTY_TH, default 8: AEMPTY asserts when count <= AEMPTY_TH.
REQ-005 The block SHALL have these ports, one per line (name, direction, width, meaning):
  CLOCK  in  1  single clock; all logic is rising-edge.
  RESET_N  in  1  asynchronous reset, active-low.
  WE  in  1  push request.
  DATA  in  WIDTH  push data.
  RE  in  1  pop request.
  Q  out  WIDTH  pop data, equal to RAM_RDATA.
  DVLD  out  1  Q valid.
  FULL, EMPTY, AFULL, AEMPTY  out  1 each  status flags.
  RAM_WEN  out  1  RAM write strobe.
  RAM_WADDR  out  ADDR_W  RAM write address.
  RAM_WDATA  out  WIDTH  RAM write data.
  RAM_REN  out  1  RAM read strobe.
  RAM_RADDR  out  ADDR_W  RAM read address.
  RAM_RDATA  in  WIDTH  RAM read data, valid 1 cycle after RAM_REN.

Function
REQ-006 The block SHALL hold write and read pointers of ADDR_W+1 bits, wrapping modulo 2^(ADDR_W+1); the RAM addresses SHALL be the low ADDR_W bits.
REQ-007 The block SHALL accept a push (wr_ok) when WE=1 and FULL=0, and a pop (rd_ok) when RE=1 and EMPTY=0; flags are the registered pre-edge values.
REQ-008 On wr_ok, combinationally: RAM_WEN=1, RAM_WADDR=wptr[ADDR_W-1:0], RAM_WDATA=DATA; wptr SHALL increment at the edge.
REQ-009 On rd_ok, combinationally: RAM_REN=1, RAM_RADDR=rptr[ADDR_W-1:0]; rptr SHALL increment at the edge; DVLD SHALL be 1 in exactly the next cycle.
REQ-010 Read latency SHALL be 1 cycle, RE to DVLD/Q.
REQ-011 The registered count (ADDR_W+1 bits) SHALL change by +1 on wr_ok only, by -1 on rd_ok only, and not at all on both or neither.
REQ-012 The flags SHALL be registered from the next count: FULL = (count==2^ADDR_W), EMPTY = (count==0), and AFULL/AEMPTY per REQ-003/004.
REQ-013 When FULL with WE=RE=1, the pop SHALL be accepted and the push dropped; count SHALL become 2^ADDR_W-1.
REQ-014 When EMPTY with WE=RE=1, the push SHALL be accepted and the pop dropped (no fall-through); DVLD=0.
REQ-015 A push when FULL and a pop when EMPTY SHALL be ignored, with no state change.
REQ-016 RAM write and read addresses SHALL never be equal in the same cycle with both strobes active.

Reset
REQ-017 While RESET_N=0: pointers, count, DVLD, FULL, AFULL = 0; EMPTY, AEMPTY = 1; RAM_WEN, RAM_REN = 0.
REQ-018 When reset is asserted mid-operation, stored data SHALL be discarded and a pending DVLD cancelled; operation SHALL resume on the first edge after release.

Configuration
REQ-019 When macro FIFO_SYNC_CTRL_STATUS_EN is defined, the block SHALL add these ports: CNT out ADDR_W+1 (the count); OVF out 1 (sticky, set by a dropped push, REQ-015); UDF out 1 (sticky, set by a dropped pop); CLR_ERR in 1 (synchronous clear of OVF/UDF, with set taking priority); OVF/UDF reset to 0.
REQ-020 When FIFO_SYNC_CTRL_STATUS_EN is undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 Reset, then push 0x11..0x14, then pop 4 -> Q=0x11,0x12,0x13,0x14, each with DVLD one cycle after RE; EMPTY=1 after the last pop.
REQ-022 Push 128 words -> FULL=1 after the 128th; AFULL=1 from count 120; a 129th push gives no RAM_WEN (and OVF=1 when the macro is defined).
REQ-023 FULL with WE=RE=1 for one cycle -> one pop accepted, RAM_WEN=0, count=127, FULL=0.
REQ-024 EMPTY with WE=RE=1 -> RAM_WEN=1, RAM_REN=0, DVLD=0 next cycle, count=1.
REQ-025 Run 300 random push/pop cycles through pointer wrap -> data order matches a reference model, and count and flags match every cycle.
REQ-026 Assert RESET_N=0 with 50 entries and a pop in flight -> DVLD=0, EMPTY=1, CNT=0 immediately, with no clock edge needed.
